// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared types for the handshaked ALU pipeline: opcode and FSM state enums,
// the result flag bundle, and a cleared-flags constant.
// Optional feature macro used by the design files: ALU_PIPE_DIV_EN
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    // Opcodes presented on ALU_Sel; 10..15 are illegal.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_CMP = 4'd9
    } alu_op_e;

    // Control FSM states; the divide states exist only when the divider is built.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_WAIT = 2'd2
    } alu_state_e;

    // Result flags, registered alongside ALU_Out.
    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic err;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_CLEAR = 4'b0000;

endpackage

// File: rtl/alu_pipe_div.sv
// -----------------------------------------------------------------------------
// alu_pipe_div
// Iterative restoring divider, one quotient bit per clock, WIDTH iterations.
// Only instantiated when ALU_PIPE_DIV_EN is defined.
// Ports:
//   Clock, Reset      clock (rising edge), asynchronous active-high reset
//   start             load dividend/divisor and begin (ignored while busy)
//   dividend, divisor WIDTH-bit unsigned operands, sampled on start
//   busy              iterations remain
//   done              the final iteration happens at the coming edge
//   quotient          quotient register (final once busy drops)
// -----------------------------------------------------------------------------
module alu_pipe_div #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int DIV_CYCLES = WIDTH;
    localparam int CW         = $clog2(DIV_CYCLES + 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not borrow. The shifted value
    // needs WIDTH+1 bits because it can reach 2*divisor-1.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dsr_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Divider registers: load on start, iterate while count is nonzero.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dsr_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (start && (count_r == {CW{1'b0}})) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= dividend;
            dsr_r   <= divisor;
            count_r <= CW'(DIV_CYCLES);
        end else if (count_r != {CW{1'b0}}) begin
            rem_r   <= rem_next_s;
            quo_r   <= quo_next_s;
            count_r <= count_r - CW'(1);
        end else begin
            rem_r   <= rem_r;
            quo_r   <= quo_r;
            count_r <= count_r;
        end
    end

    assign busy     = (count_r != {CW{1'b0}});
    assign done     = (count_r == CW'(1));
    assign quotient = quo_r;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU with registered results. Requests arrive on a valid/ready
// channel; results and flags are held in output registers until consumed.
// Single-cycle ops register their result at the accept edge. DIV uses an
// iterative restoring divider when ALU_PIPE_DIV_EN is defined; otherwise DIV
// is an illegal opcode and the FSM never leaves IDLE.
// Ports:
//   Clock, Reset        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   request handshake for A, B, ALU_Sel
//   A, B                WIDTH-bit unsigned operands
//   ALU_Sel             4-bit opcode
//   out_valid/out_ready result handshake
//   ALU_Out             WIDTH-bit result
//   Carry_Out           carry (ADD) / borrow (SUB) / high product nonzero (MUL)
//   Zero_Out            ALU_Out == 0
//   Ovf_Out             signed overflow (ADD/SUB)
//   Err_Out             divide by zero or illegal opcode
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Carry_Out,
    output logic             Zero_Out,
    output logic             Ovf_Out,
    output logic             Err_Out
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_e          op_s;
    alu_state_e       state_r;
    alu_state_e       state_next_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] comb_out_s;
    alu_flags_t       comb_flags_s;
    logic [WIDTH-1:0] next_out_s;
    alu_flags_t       next_flags_s;
    logic [WIDTH-1:0] alu_out_r;
    alu_flags_t       flags_r;
    logic             out_valid_r;
    logic             init_done_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quot_s;
    logic             wait_release_s;
    logic             result_load_s;

    assign op_s = alu_op_e'(ALU_Sel);

    // Single-cycle result and flags for the request currently on the input.
    always_comb begin
        sum_s        = {1'b0, A} + {1'b0, B};
        diff_s       = {1'b0, A} - {1'b0, B};
        prod_s       = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        comb_out_s   = {WIDTH{1'b0}};
        comb_flags_s = FLAGS_CLEAR;
        case (op_s)
            OP_ADD: begin
                comb_out_s         = sum_s[WIDTH-1:0];
                comb_flags_s.carry = sum_s[WIDTH];
                comb_flags_s.ovf   = (A[WIDTH-1] == B[WIDTH-1]) &&
                                     (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra bit of the widened difference is the borrow (A < B).
                comb_out_s         = diff_s[WIDTH-1:0];
                comb_flags_s.carry = diff_s[WIDTH];
                comb_flags_s.ovf   = (A[WIDTH-1] != B[WIDTH-1]) &&
                                     (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: begin
                comb_out_s         = prod_s[WIDTH-1:0];
                comb_flags_s.carry = |prod_s[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
`ifdef ALU_PIPE_DIV_EN
                // Only reaches the output registers for B == 0; a nonzero
                // divisor goes through the divider instead.
                comb_out_s       = {WIDTH{1'b1}};
                comb_flags_s.err = 1'b1;
`else
                comb_out_s       = {WIDTH{1'b0}};
                comb_flags_s.err = 1'b1;
`endif
            end
            OP_AND: comb_out_s = A & B;
            OP_OR:  comb_out_s = A | B;
            OP_XOR: comb_out_s = A ^ B;
            OP_SHL: comb_out_s = A << B[SHW-1:0];
            OP_SHR: comb_out_s = A >> B[SHW-1:0];
            OP_CMP: comb_out_s = {{(WIDTH-1){1'b0}}, (A < B)};
            default: begin
                comb_out_s       = {WIDTH{1'b0}};
                comb_flags_s.err = 1'b1;
            end
        endcase
        comb_flags_s.zero = (comb_out_s == {WIDTH{1'b0}});
    end

`ifdef ALU_PIPE_DIV_EN
    assign div_start_s = accept_s && (op_s == OP_DIV) && (B != {WIDTH{1'b0}});

    alu_pipe_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .Clock    (Clock),
        .Reset    (Reset),
        .start    (div_start_s),
        .dividend (A),
        .divisor  (B),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );
`else
    assign div_start_s = 1'b0;
    assign div_busy_s  = 1'b0;
    assign div_done_s  = 1'b0;
    assign div_quot_s  = {WIDTH{1'b0}};
`endif

    // init_done_r keeps in_ready low until the first edge after Reset releases.
    assign in_ready_s     = init_done_r && (state_r == IDLE) && (!out_valid_r || out_ready);
    assign accept_s       = in_valid && in_ready_s;
    assign wait_release_s = (state_r == DIV_WAIT) && (!out_valid_r || out_ready);
    assign result_load_s  = (accept_s && !div_start_s) || wait_release_s;

    // Next-state logic for the divide sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_start_s) begin
                    state_next_s = DIV_BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV_BUSY: begin
                // Falling back to IDLE if the divider is idle recovers from
                // an inconsistent state instead of hanging.
                if (div_done_s) begin
                    state_next_s = DIV_WAIT;
                end else if (div_busy_s) begin
                    state_next_s = DIV_BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV_WAIT: begin
                if (wait_release_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DIV_WAIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Select what gets written into the output registers.
    always_comb begin
        if (state_r == DIV_WAIT) begin
            next_out_s        = div_quot_s;
            next_flags_s      = FLAGS_CLEAR;
            next_flags_s.zero = (div_quot_s == {WIDTH{1'b0}});
        end else begin
            next_out_s   = comb_out_s;
            next_flags_s = comb_flags_s;
        end
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Ready-enable flag that becomes set on the first edge out of reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b1;
        end
    end

    // Output registers: a new result overwrites even while the old one is
    // being consumed; otherwise a consume only clears out_valid.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid_r <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            flags_r     <= FLAGS_CLEAR;
        end else if (result_load_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= next_out_s;
            flags_r     <= next_flags_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign ALU_Out   = alu_out_r;
    assign Carry_Out = flags_r.carry;
    assign Zero_Out  = flags_r.zero;
    assign Ovf_Out   = flags_r.ovf;
    assign Err_Out   = flags_r.err;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the team's 8-bit registered ALU, with configurable datapath width. Operands enter on a valid/ready input channel and results leave on a registered valid/ready output channel with a full flag set. Single-cycle ops complete in one cycle; divide uses an iterative restoring divider.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
DIV_CYCLES, WIDTH, divider iterations; fixed equal to WIDTH

Ports:
Clock  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  A/B/ALU_Sel valid
in_ready  output  1  block can accept a request this cycle
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
ALU_Sel  input  4  opcode
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  consumer accepts result
ALU_Out  output  WIDTH  result
Carry_Out  output  1  carry (ADD) / borrow (SUB) / high-product-nonzero (MUL)
Zero_Out  output  1  ALU_Out == 0
Ovf_Out  output  1  signed overflow (ADD/SUB only)
Err_Out  output  1  divide-by-zero or illegal opcode

Behaviour:
- Reset: all outputs 0, in_ready 0 while Reset asserted, FSM IDLE, divider regs 0. in_ready rises the first cycle after Reset deasserts.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 SHL (A << B[log2 WIDTH-1:0]), 8 SHR logical, 9 CMP (ALU_Out = {0.., A<B}), 10-15 illegal.
- ADD: {Carry, Out} = A+B, WIDTH+1 bits. SUB: Out = A-B, Carry = (A<B). Ovf = signed overflow of the MSB.
- MUL: Out = low WIDTH bits of the 2*WIDTH product; Carry = |high WIDTH bits.
- Illegal opcode: Out = 0, Err = 1, Zero = 1, other flags 0.
- Non-arith ops: Carry = 0, Ovf = 0.
- Handshake: a request transfers when in_valid && in_ready at a rising edge. A result transfers when out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops sustain 1 per cycle.
- FSM states:
  - IDLE: single-cycle op accepted → result registered at the same edge; out_valid = 1 from the next cycle (latency 1).
  - IDLE, DIV accepted with B != 0 → DIV_BUSY; load remainder = 0, quotient = A, count = WIDTH.
  - IDLE, DIV accepted with B == 0 → immediate result: Out = all-ones, Err = 1, latency 1, no DIV_BUSY.
  - DIV_BUSY: one restoring step per cycle; count decrements. At count == 1, go to DIV_WAIT.
  - DIV_WAIT: if !out_valid || out_ready, write quotient to ALU_Out (Carry = 0, Ovf = 0, Zero per result), set out_valid, go to IDLE. Total latency WIDTH+1 cycles from accept to out_valid when the output is unblocked.
- out_valid with out_ready low: ALU_Out and all flags hold stable; no new request is accepted.
- Simultaneous consume and accept in the same cycle: the new result overwrites, out_valid stays 1.
- A/B/ALU_Sel are sampled only at the accept edge; later changes are ignored.
- Reset mid-divide: aborts immediately, results lost, all outputs 0.

Optional Feature:
Macro: ALU_PIPE_DIV_EN
- Defined: the divider and DIV_BUSY/DIV_WAIT states are compiled in, as above.
- Undefined: no divider logic. DIV (opcode 3) is treated as illegal (Out = 0, Err = 1, latency 1), and the FSM never leaves IDLE.

Decomposition:
- Package alu_pipe_pkg: alu_op_e enum (4-bit opcodes), alu_state_e enum (IDLE, DIV_BUSY, DIV_WAIT), OP_* constants, a flags struct {carry, zero, ovf, err}.
- Sub-module alu_pipe_div: iterative restoring divider with start/busy/done, WIDTH parameter; instantiated only under ALU_PIPE_DIV_EN.

Test Plan:
- WIDTH=8, ADD A=8'hF0 B=8'h20, out_ready=1 → next cycle ALU_Out=8'h10, Carry=1, Zero=0, Ovf=0.
- SUB A=8'h80 B=8'h01 → ALU_Out=8'h7F, Carry=0, Ovf=1. Then SUB 5-7 → 8'hFE, Carry=1.
- DIV A=200 B=7 → out_valid after 9 cycles, ALU_Out=28, in_ready=0 throughout. DIV A=9 B=0 → ALU_Out=8'hFF, Err=1, latency 1.
- Hold out_ready=0 after a MUL 16×16 (Out=0, Carry=1) while in_valid stays high → in_ready=0, outputs stable for 5 cycles. Raise out_ready → the next request is accepted that cycle.
- Stream 20 random single-cycle ops with out_ready=1 → 1 result per cycle, in order, matching the model. Opcode 4'hC → Out=0, Err=1.
- Assert Reset during DIV_BUSY → all outputs 0 asynchronously; after release in_ready=1 the next cycle and the FSM is in IDLE.
